shifter_extender_pipe: RTL and testbench
========================================

Name: shifter_extender_pipe

Overview:
- Parametrised, two-stage pipelined successor to the combinational shifter/extender.
- Performs LSL/LSR/ASR/ROR/RRX shifts with ARM-style carry-out, plus byte/halfword sign/zero extension, on a WIDTH-bit operand.
- Sits between operand fetch and the ALU. Uses a valid/ready handshake with full-throughput backpressure and a synchronous flush.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥16 and a power of 2.
- AMT_W, 6, shift-amount width; must satisfy 2^AMT_W ≥ 2*WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline clear.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift amount, unsigned.
- in_op  in  3  operation select.
- in_ext  in  1  0 = shift group, 1 = extend group.
- in_cin  in  1  carry in (C flag).
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_cout  out  1  carry out.

Behaviour:
Reset and flush
- rst_n low: internal valids, out_valid, out_data and out_cout all go to 0 immediately. in_ready reads 1 once s1_valid is 0.
- flush at a clock edge clears s1_valid and s2_valid. Data registers are don't-care after a flush.
- A flush coinciding with in_valid&&in_ready drops that request.

Handshake
- A transfer occurs when valid && ready on the same rising edge.
- s1_adv = !s2_valid || out_ready. in_ready = !s1_valid || s1_adv (combinational).
- Latency: accepted at edge N → out_valid at edge N+2, with no stall. Throughput is 1 per cycle.
- While out_valid && !out_ready, out_data and out_cout hold stable. Once out_valid rises, it stays high until the transfer.
- Stage 1 registers the inputs. Stage 2 registers the computed result.

Shift group (in_ext=0); A = amt, W = WIDTH:
- A = 0, any shift op except RRX: data = in, cout = cin.
- op0 LSL:
  - A<W: data = in<<A, cout = in[W-A].
  - A=W: data = 0, cout = in[0].
  - A>W: data = 0, cout = 0.
- op1 LSR:
  - A<W: data = in>>A, cout = in[A-1].
  - A=W: data = 0, cout = in[W-1].
  - A>W: data = 0, cout = 0.
- op2 ASR:
  - A<W: arithmetic shift right, cout = in[A-1].
  - A≥W: every bit = in[W-1], cout = in[W-1].
- op3 ROR: R = A mod W.
  - R≠0: rotate right by R, cout = data[W-1].
  - R=0 with A≠0: data = in, cout = in[W-1].
- op4 RRX: amount ignored; data = {cin, in[W-1:1]}, cout = in[0].
- op5–7: pass-through (data = in, cout = cin).

Extend group (in_ext=1); cout = cin for every op:
- op0: sign-extend in[7:0].
- op1: zero-extend in[7:0].
- op2: sign-extend in[15:0].
- op3: zero-extend in[15:0].
- op4–7: pass-through.

General
- No X propagation from unused amount bits. All arithmetic is unsigned except ASR.

Test Plan (WIDTH=32):
1. Reset mid-stream: two requests in flight, pulse rst_n low asynchronously → out_valid drops without waiting for a clock edge; out_data = 0, out_cout = 0; no stale result after release.
2. Shift boundaries:
   - LSL in=0x80000001, A=1 → 0x00000002, cout=1.
   - LSL A=32 → 0, cout=1.
   - LSL A=33 → 0, cout=0.
   - LSR A=0 with cin=1 → data = in, cout=1.
3. ASR/ROR/RRX:
   - ASR 0x80000000 A=40 → 0xFFFFFFFF, cout=1.
   - ROR 0x00000001 A=1 → 0x80000000, cout=1.
   - ROR A=32 with in=0x80000000 → data = in, cout=1.
   - RRX in=0x00000003, cin=1 → 0x80000001, cout=1.
4. Extension:
   - ext op0 in=0x12345680 → 0xFFFFFF80.
   - ext op1 same input → 0x00000080.
   - ext op2 in=0x00008001 → 0xFFFF8001.
   - ext op3 same input → 0x00008001.
   - cout = cin in all four cases.
5. Backpressure: stream 8 back-to-back requests, hold out_ready low for 3 cycles mid-stream →
   - in_ready drops after both stages fill;
   - out_data stays stable while stalled;
   - all 8 results arrive in order with none lost or duplicated;
   - with out_ready held at 1, one result per cycle at latency 2.
6. Flush: flush asserted together with a new accept while 2 requests are in flight → next out_valid comes only from the first request accepted after the flush.

Source files
------------

// File: rtl/shifter_extender_pipe.sv
// shifter_extender_pipe
//   Two-stage pipelined barrel shifter / sign-zero extender placed between
//   operand fetch and the ALU. Stage 1 registers the request, stage 2
//   registers the computed result. Valid/ready handshake on both sides with
//   full-throughput backpressure and a synchronous flush.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   flush             synchronous clear of both pipeline stages
//   in_valid/in_ready request handshake
//   in_data           WIDTH-bit operand
//   in_amt            AMT_W-bit unsigned shift amount
//   in_op             operation select (meaning depends on in_ext)
//   in_ext            0 = shift group, 1 = extend group
//   in_cin            carry in (C flag)
//   out_valid/out_ready result handshake
//   out_data, out_cout result and carry out
module shifter_extender_pipe #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic [2:0]       in_op,
    input  logic             in_ext,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        SH_LSL = 3'd0,
        SH_LSR = 3'd1,
        SH_ASR = 3'd2,
        SH_ROR = 3'd3,
        SH_RRX = 3'd4
    } shift_op_e;

    typedef enum logic [2:0] {
        EX_SXB = 3'd0,
        EX_UXB = 3'd1,
        EX_SXH = 3'd2,
        EX_UXH = 3'd3
    } ext_op_e;

    // Stage 1: registered request
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic [AMT_W-1:0] r_s1_amt;
    logic [2:0]       r_s1_op;
    logic             r_s1_ext;
    logic             r_s1_cin;

    // Stage 2: registered result
    logic             r_s2_valid;
    logic [WIDTH-1:0] r_s2_data;
    logic             r_s2_cout;

    logic             w_s1_adv;
    logic             w_in_ready;
    logic             w_amt_zero;
    logic [WIDTH:0]   w_lsl_wide;
    logic [WIDTH:0]   w_lsr_wide;
    logic [AMT_W-1:0] w_asr_amt;
    logic signed [WIDTH:0] w_asr_wide;
    logic [SH_W-1:0]  w_ror_amt;
    logic [SH_W:0]    w_ror_lsh;
    logic [WIDTH-1:0] w_ror_data;
    logic [WIDTH-1:0] w_res_data;
    logic             w_res_cout;

    assign w_s1_adv   = !r_s2_valid || out_ready;
    assign w_in_ready = !r_s1_valid || w_s1_adv;
    assign in_ready   = w_in_ready;

    assign out_valid  = r_s2_valid;
    assign out_data   = r_s2_data;
    assign out_cout   = r_s2_cout;

    // Each shifter carries one extra bit beyond the result: the last bit
    // shifted out, which is exactly the ARM carry for 0 < A <= W and falls
    // to 0 (LSL/LSR) for larger amounts.
    assign w_amt_zero = (r_s1_amt == '0);
    assign w_lsl_wide = {1'b0, r_s1_data} << r_s1_amt;
    assign w_lsr_wide = {r_s1_data, 1'b0} >> r_s1_amt;
    // ASR saturates at W: every result bit and the carry become the sign.
    assign w_asr_amt  = (r_s1_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : r_s1_amt;
    assign w_asr_wide = $signed({r_s1_data, 1'b0}) >>> w_asr_amt;
    // Rotate by A mod W; a left shift by W (when R = 0) contributes nothing.
    assign w_ror_amt  = r_s1_amt[SH_W-1:0];
    assign w_ror_lsh  = (SH_W+1)'(WIDTH) - {1'b0, w_ror_amt};
    assign w_ror_data = (r_s1_data >> w_ror_amt) | (r_s1_data << w_ror_lsh);

    always_comb begin
        w_res_data = r_s1_data;
        w_res_cout = r_s1_cin;
        if (r_s1_ext) begin
            case (r_s1_op)
                EX_SXB:  w_res_data = {{(WIDTH-8){r_s1_data[7]}}, r_s1_data[7:0]};
                EX_UXB:  w_res_data = {{(WIDTH-8){1'b0}}, r_s1_data[7:0]};
                EX_SXH:  w_res_data = {{(WIDTH-16){r_s1_data[15]}}, r_s1_data[15:0]};
                EX_UXH:  w_res_data = {{(WIDTH-16){1'b0}}, r_s1_data[15:0]};
                default: ;
            endcase
        end else begin
            case (r_s1_op)
                SH_LSL: if (!w_amt_zero) begin
                    w_res_data = w_lsl_wide[WIDTH-1:0];
                    w_res_cout = w_lsl_wide[WIDTH];
                end
                SH_LSR: if (!w_amt_zero) begin
                    w_res_data = w_lsr_wide[WIDTH:1];
                    w_res_cout = w_lsr_wide[0];
                end
                SH_ASR: if (!w_amt_zero) begin
                    w_res_data = w_asr_wide[WIDTH:1];
                    w_res_cout = w_asr_wide[0];
                end
                SH_ROR: if (!w_amt_zero) begin
                    w_res_data = w_ror_data;
                    w_res_cout = w_ror_data[WIDTH-1];
                end
                SH_RRX: begin
                    w_res_data = {r_s1_cin, r_s1_data[WIDTH-1:1]};
                    w_res_cout = r_s1_data[0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_amt   <= '0;
            r_s1_op    <= '0;
            r_s1_ext   <= 1'b0;
            r_s1_cin   <= 1'b0;
        end else begin
            if (flush) begin
                r_s1_valid <= 1'b0;
            end else if (w_in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (in_valid && w_in_ready) begin
                r_s1_data <= in_data;
                r_s1_amt  <= in_amt;
                r_s1_op   <= in_op;
                r_s1_ext  <= in_ext;
                r_s1_cin  <= in_cin;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_cout  <= 1'b0;
        end else begin
            if (flush) begin
                r_s2_valid <= 1'b0;
            end else if (w_s1_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            // Result only moves when stage 2 frees up, so it holds while stalled.
            if (w_s1_adv && r_s1_valid) begin
                r_s2_data <= w_res_data;
                r_s2_cout <= w_res_cout;
            end
        end
    end

endmodule

// File: tb/tb_shifter_extender_pipe.sv
module tb_shifter_extender_pipe;

    localparam int W  = 32;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n, flush, in_valid, in_ready, in_ext, in_cin;
    logic          out_valid, out_ready, out_cout;
    logic [W-1:0]  in_data, out_data;
    logic [AW-1:0] in_amt;
    logic [2:0]    in_op;

    shifter_extender_pipe #(.WIDTH(W), .AMT_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_amt(in_amt), .in_op(in_op), .in_ext(in_ext), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_cout(out_cout)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int xfer_cnt = 0;
    int xfer_first = 0;
    int xfer_last = 0;

    logic [W:0] exp_q[$];
    logic [W:0] cur_exp;
    logic       last_acc, last_xfer, last_ir, last_ov;
    logic [W:0] last_got;

    typedef struct {
        logic [2:0]   op;
        logic         ext;
        logic [W-1:0] d;
        int           amt;
        logic         cin;
        logic [W-1:0] ed;
        logic         ec;
    } vec_t;

    vec_t tbl[19];

    // Reference model: every result bit derived from its source index.
    function automatic logic [W:0] model(input logic [2:0] op, input logic ext,
                                         input logic [W-1:0] d, input int a,
                                         input logic cin);
        logic [W-1:0] r;
        logic         c;
        int           s;
        r = d;
        c = cin;
        if (ext) begin
            for (int i = 0; i < W; i++) begin
                case (op)
                    3'd0:    r[i] = (i < 8)  ? d[i] : d[7];
                    3'd1:    r[i] = (i < 8)  ? d[i] : 1'b0;
                    3'd2:    r[i] = (i < 16) ? d[i] : d[15];
                    3'd3:    r[i] = (i < 16) ? d[i] : 1'b0;
                    default: r[i] = d[i];
                endcase
            end
        end else if (op == 3'd4) begin
            r = (d >> 1) | (W'(cin) << (W - 1));
            c = d[0];
        end else if (op <= 3'd3 && a != 0) begin
            for (int i = 0; i < W; i++) begin
                case (op)
                    3'd0: begin s = i - a; r[i] = (s >= 0) ? d[s] : 1'b0; end
                    3'd1: begin s = i + a; r[i] = (s < W) ? d[s] : 1'b0; end
                    3'd2: begin s = i + a; r[i] = (s < W) ? d[s] : d[W-1]; end
                    default: r[i] = d[(i + a) % W];
                endcase
            end
            case (op)
                3'd0:    c = (W - a >= 0) ? d[W-a] : 1'b0;
                3'd1:    c = (a - 1 < W) ? d[a-1] : 1'b0;
                3'd2:    c = (a - 1 < W) ? d[a-1] : d[W-1];
                default: c = r[W-1];
            endcase
        end
        return {c, r};
    endfunction

    task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {{W{1'b0}}, act}, {{W{1'b0}}, exp});
    endtask

    // One clock: sample handshakes at the falling edge, then score the
    // transfers that happen at the following rising edge.
    task cycle();
        @(negedge clk);
        last_acc  = in_valid && in_ready;
        last_xfer = out_valid && out_ready;
        last_ir   = in_ready;
        last_ov   = out_valid;
        last_got  = {out_cout, out_data};
        @(posedge clk);
        #1;
        cyc++;
        if (last_xfer) begin
            xfer_cnt++;
            if (xfer_cnt == 1) xfer_first = cyc;
            xfer_last = cyc;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_out: got %h expected no result", last_got);
            end else begin
                check("out", last_got, exp_q.pop_front());
            end
        end
        if (flush) exp_q.delete();
        else if (last_acc) exp_q.push_back(cur_exp);
    endtask

    task send(input logic [2:0] op, input logic ext, input logic [W-1:0] d,
              input int a, input logic cin, input logic [W:0] e);
        in_valid = 1'b1;
        in_op    = op;
        in_ext   = ext;
        in_data  = d;
        in_amt   = AW'(a);
        in_cin   = cin;
        cur_exp  = e;
        for (int t = 0; t < 20; t++) begin
            cycle();
            if (last_acc) break;
        end
        if (!last_acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0 expected accept");
        end
        in_valid = 1'b0;
    endtask

    task drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 20 && exp_q.size() > 0; t++) cycle();
        check("drain_left", (W+1)'(exp_q.size()), '0);
        exp_q.delete();
    endtask

    task rand_req();
        int a;
        logic [2:0] op;
        logic ext, cin;
        logic [W-1:0] d;
        op  = 3'($urandom_range(0, 7));
        ext = ($urandom_range(0, 3) == 0);
        d   = $urandom;
        cin = 1'($urandom);
        case ($urandom_range(0, 7))
            0: a = 0;
            1: a = W;
            2: a = W + 1;
            3: a = W - 1;
            default: a = $urandom_range(0, 63);
        endcase
        in_op = op; in_ext = ext; in_data = d; in_amt = AW'(a); in_cin = cin;
        cur_exp = model(op, ext, d, a, cin);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc;
        int idx;
        logic ir_drop, have_prev;
        logic [W:0] prev;

        tbl[0]  = '{3'd0, 1'b0, 32'h80000001, 1,  1'b0, 32'h00000002, 1'b1};
        tbl[1]  = '{3'd0, 1'b0, 32'h80000001, 32, 1'b0, 32'h00000000, 1'b1};
        tbl[2]  = '{3'd0, 1'b0, 32'h80000001, 33, 1'b1, 32'h00000000, 1'b0};
        tbl[3]  = '{3'd1, 1'b0, 32'h12345678, 0,  1'b1, 32'h12345678, 1'b1};
        tbl[4]  = '{3'd2, 1'b0, 32'h80000000, 40, 1'b0, 32'hFFFFFFFF, 1'b1};
        tbl[5]  = '{3'd3, 1'b0, 32'h00000001, 1,  1'b0, 32'h80000000, 1'b1};
        tbl[6]  = '{3'd3, 1'b0, 32'h80000000, 32, 1'b0, 32'h80000000, 1'b1};
        tbl[7]  = '{3'd4, 1'b0, 32'h00000003, 7,  1'b1, 32'h80000001, 1'b1};
        tbl[8]  = '{3'd0, 1'b1, 32'h12345680, 0,  1'b0, 32'hFFFFFF80, 1'b0};
        tbl[9]  = '{3'd1, 1'b1, 32'h12345680, 0,  1'b1, 32'h00000080, 1'b1};
        tbl[10] = '{3'd2, 1'b1, 32'h00008001, 0,  1'b0, 32'hFFFF8001, 1'b0};
        tbl[11] = '{3'd3, 1'b1, 32'h00008001, 0,  1'b1, 32'h00008001, 1'b1};
        tbl[12] = '{3'd1, 1'b0, 32'h80000001, 32, 1'b0, 32'h00000000, 1'b1};
        tbl[13] = '{3'd1, 1'b0, 32'h00000003, 1,  1'b0, 32'h00000001, 1'b1};
        tbl[14] = '{3'd2, 1'b0, 32'h80000010, 4,  1'b1, 32'hF8000001, 1'b0};
        tbl[15] = '{3'd3, 1'b0, 32'h12345678, 4,  1'b0, 32'h81234567, 1'b1};
        tbl[16] = '{3'd5, 1'b0, 32'h0000ABCD, 3,  1'b1, 32'h0000ABCD, 1'b1};
        tbl[17] = '{3'd6, 1'b1, 32'hCAFEF00D, 9,  1'b0, 32'hCAFEF00D, 1'b0};
        tbl[18] = '{3'd2, 1'b0, 32'h40000000, 63, 1'b1, 32'h00000000, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_amt = '0; in_op = '0; in_ext = 1'b0; in_cin = 1'b0;
        cur_exp = '0;
        #2;
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bit("rst_in_ready", in_ready, 1'b1);
        check("rst_out", {out_cout, out_data}, '0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed vectors from the table, streamed back to back
        for (int i = 0; i < 19; i++)
            send(tbl[i].op, tbl[i].ext, tbl[i].d, tbl[i].amt, tbl[i].cin, {tbl[i].ec, tbl[i].ed});
        drain();

        // Latency: accept edge to output transfer edge
        xfer_cnt = 0;
        send(3'd0, 1'b0, 32'h1, 4, 1'b0, model(3'd0, 1'b0, 32'h1, 4, 1'b0));
        acc_cyc = cyc;
        for (int t = 0; t < 10 && xfer_cnt == 0; t++) cycle();
        check("latency", (W+1)'(xfer_first - acc_cyc), (W+1)'(2));
        drain();

        // Throughput: 8 back to back with out_ready high
        xfer_cnt = 0;
        for (int i = 0; i < 8; i++)
            send(3'd1, 1'b0, 32'hF0000000 + i, i, 1'b1, model(3'd1, 1'b0, 32'hF0000000 + i, i, 1'b1));
        for (int t = 0; t < 10 && xfer_cnt < 8; t++) cycle();
        check("thru_count", (W+1)'(xfer_cnt), (W+1)'(8));
        check("thru_span", (W+1)'(xfer_last - xfer_first), (W+1)'(7));
        drain();

        // Backpressure: out_ready low for 3 cycles mid-stream
        xfer_cnt = 0; idx = 0; ir_drop = 1'b0; have_prev = 1'b0; prev = '0;
        for (int k = 0; k < 40 && (idx < 8 || exp_q.size() > 0); k++) begin
            out_ready = !(k >= 4 && k < 7);
            if (idx < 8) begin
                in_valid = 1'b1;
                rand_req();
            end else begin
                in_valid = 1'b0;
            end
            cycle();
            if (last_acc) idx++;
            if (!last_ir) ir_drop = 1'b1;
            if (last_ov && !out_ready) begin
                if (have_prev) check("stall_hold", last_got, prev);
                prev = last_got;
                have_prev = 1'b1;
            end else begin
                have_prev = 1'b0;
            end
        end
        check_bit("bp_in_ready_dropped", ir_drop, 1'b1);
        check("bp_results", (W+1)'(xfer_cnt), (W+1)'(8));
        drain();

        // Flush together with an accept while two requests are in flight
        send(3'd0, 1'b0, 32'hAAAA0001, 1, 1'b0, model(3'd0, 1'b0, 32'hAAAA0001, 1, 1'b0));
        send(3'd0, 1'b0, 32'hBBBB0002, 2, 1'b0, model(3'd0, 1'b0, 32'hBBBB0002, 2, 1'b0));
        in_valid = 1'b1; in_op = 3'd1; in_ext = 1'b0; in_data = 32'hCCCC0003;
        in_amt = 6'd3; in_cin = 1'b0; cur_exp = '0;
        flush = 1'b1;
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        check_bit("flush_accept_offered", last_acc, 1'b1);
        check_bit("flush_out_valid", out_valid, 1'b0);
        cycle();
        check_bit("flush_idle_out_valid", out_valid, 1'b0);
        send(3'd3, 1'b0, 32'hDDDD0004, 8, 1'b0, model(3'd3, 1'b0, 32'hDDDD0004, 8, 1'b0));
        drain();

        // Asynchronous reset with two requests in flight
        out_ready = 1'b0;
        send(3'd0, 1'b0, 32'h00000011, 1, 1'b1, model(3'd0, 1'b0, 32'h11, 1, 1'b1));
        send(3'd0, 1'b0, 32'h00000022, 2, 1'b1, model(3'd0, 1'b0, 32'h22, 2, 1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("arst_out_valid", out_valid, 1'b0);
        check("arst_out", {out_cout, out_data}, '0);
        check_bit("arst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int t = 0; t < 4; t++) cycle();
        check_bit("post_rst_out_valid", out_valid, 1'b0);

        // Randomized traffic with random backpressure
        for (int k = 0; k < 400; k++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 4) != 0);
            rand_req();
            cycle();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
